// File: rtl/seven_segment_p_pkg.sv
// Shared constants for the seven-segment display peripheral: register
// addresses and the active-low blank levels for the board pins.
package seven_segment_p_pkg;

    localparam logic [3:0] ADDR_VALUE   = 4'd0;
    localparam logic [3:0] ADDR_DIGMASK = 4'd1;
    localparam logic [3:0] ADDR_DPMASK  = 4'd2;
    localparam logic [3:0] ADDR_CTRL    = 4'd3;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

endpackage

// File: rtl/seven_segment_p_hex_to_7seg.sv
// Combinational hex digit to seven-segment decoder.
// The output is active-high in the bit order {g,f,e,d,c,b,a}.
module hex_to_7seg (
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'h00;
        case (nibble_i)
            4'h0: seg_o = 7'h3F;
            4'h1: seg_o = 7'h06;
            4'h2: seg_o = 7'h5B;
            4'h3: seg_o = 7'h4F;
            4'h4: seg_o = 7'h66;
            4'h5: seg_o = 7'h6D;
            4'h6: seg_o = 7'h7D;
            4'h7: seg_o = 7'h07;
            4'h8: seg_o = 7'h7F;
            4'h9: seg_o = 7'h6F;
            4'hA: seg_o = 7'h77;
            4'hB: seg_o = 7'h7C;
            4'hC: seg_o = 7'h39;
            4'hD: seg_o = 7'h5E;
            4'hE: seg_o = 7'h79;
            4'hF: seg_o = 7'h71;
            default: seg_o = 7'h00;
        endcase
    end

endmodule

// File: rtl/seven_segment_p.sv
// Memory-mapped driver for an 8-digit multiplexed seven-segment display.
// It holds the register file, the read port, the refresh scan and the registered pin drivers.
module seven_segment_p
    import seven_segment_p_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  addra,
    input  logic [31:0] dina,
    input  logic        wea,
    output logic [31:0] douta,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [7:0]  an
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [31:0]      value_q;
    logic [7:0]       digMask_q;
    logic [7:0]       dpMask_q;
    logic             en_q;
    logic [31:0]      readData_d;
    logic [31:0]      douta_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [6:0]       seg_q;
    logic             dp_q;
    logic [7:0]       an_q;
    logic [6:0]       hexSeg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q   <= '0;
            digMask_q <= '0;
            dpMask_q  <= '0;
            en_q      <= 1'b0;
        end else if (wea) begin
            case (addra)
                ADDR_VALUE:   value_q   <= dina;
                ADDR_DIGMASK: digMask_q <= dina[7:0];
                ADDR_DPMASK:  dpMask_q  <= dina[7:0];
                ADDR_CTRL:    en_q      <= dina[0];
                default:      ;
            endcase
        end
    end

    // The read mux looks at the pre-write register values, giving read-before-write.
    always_comb begin
        readData_d = '0;
        case (addra)
            ADDR_VALUE:   readData_d = value_q;
            ADDR_DIGMASK: readData_d = {24'h0, digMask_q};
            ADDR_DPMASK:  readData_d = {24'h0, dpMask_q};
            ADDR_CTRL:    readData_d = {31'h0, en_q};
            default:      readData_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) douta_q <= '0;
        else     douta_q <= readData_d;
    end

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    hex_to_7seg u_hex (
        .nibble_i (value_q[{idx_q, 2'b00} +: 4]),
        .seg_o    (hexSeg)
    );

    // Disabled slots still take their turn in the scan; they are simply driven blank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
            an_q  <= AN_OFF;
        end else if (en_q && digMask_q[idx_q]) begin
            seg_q <= ~hexSeg;
            dp_q  <= ~dpMask_q[idx_q];
            an_q  <= ~(8'b1 << idx_q);
        end else begin
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
            an_q  <= AN_OFF;
        end
    end

    assign douta = douta_q;
    assign seg   = seg_q;
    assign dp    = dp_q;
    assign an    = an_q;

endmodule

// File: tb/tb_seven_segment_p.sv
// Directed self-checking bench for seven_segment_p with a short refresh period.
// Scan position is derived from an independent count of clock edges since reset release.
module tb_seven_segment_p;

    logic        clk;
    logic        rst;
    logic [3:0]  addra;
    logic [31:0] dina;
    logic        wea;
    logic [31:0] douta;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  an;

    int total;
    int bad;
    int edgeCount;

    // Hand-computed per-slot expectations (slot k = rightmost digit + k).
    logic [7:0] anTab[8]   = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    // VALUE 0x12345678: digits 8,7,6,5,4,3,2,1 (active-low)
    logic [6:0] segTabA[8] = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    // VALUE 0xFEDCBA98: digits 8,9,A,b,C,d,E,F (active-low)
    logic [6:0] segTabB[8] = '{7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seven_segment_p #(.REFRESH_DIV(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .addra (addra),
        .dina  (dina),
        .wea   (wea),
        .douta (douta),
        .seg   (seg),
        .dp    (dp),
        .an    (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedges seen since reset was last released
    always @(posedge clk or posedge rst) begin
        if (rst) edgeCount <= 0;
        else     edgeCount <= edgeCount + 1;
    end

    function automatic int curSlot();
        return ((edgeCount - 1) / 4) % 8;
    endfunction

    task automatic applyStimulus(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        addra = a;
        dina  = d;
        wea   = 1'b1;
        @(negedge clk);
        wea   = 1'b0;
    endtask

    task automatic readReg(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        addra = a;
        wea   = 1'b0;
        @(negedge clk);
        d = douta;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || douta !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_hold an=%h seg=%h dp=%b douta=%h required an=ff seg=7f dp=1 douta=0", an, seg, dp, douta);
        end
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            total++;
            if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1) begin
                bad++;
                $display("[TB] FAIL blank_after_reset cyc=%0d an=%h seg=%h dp=%b required an=ff seg=7f dp=1", i, an, seg, dp);
            end
        end
        for (int a = 0; a < 4; a++) begin
            readReg(4'(a), rd);
            total++;
            if (rd !== 32'h0) begin
                bad++;
                $display("[TB] FAIL reset_reg addr=%0d got=%h required=0", a, rd);
            end
        end
    endtask

    task automatic test_scan_all();
        int s;
        applyStimulus(4'd0, 32'h12345678);
        applyStimulus(4'd1, 32'h000000FF);
        applyStimulus(4'd3, 32'h00000001);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            s = curSlot();
            total++;
            if (an !== anTab[s] || seg !== segTabA[s] || dp !== 1'b1) begin
                bad++;
                $display("[TB] FAIL scan_all slot=%0d an=%h seg=%h dp=%b required an=%h seg=%h dp=1", s, an, seg, dp, anTab[s], segTabA[s]);
            end
        end
    endtask

    task automatic test_masks();
        int s;
        logic [7:0] expAn;
        logic [6:0] expSeg;
        logic       expDp;
        applyStimulus(4'd1, 32'h00000005);
        applyStimulus(4'd2, 32'h00000004);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            s = curSlot();
            if (s == 0) begin
                expAn = 8'hFE; expSeg = 7'h00; expDp = 1'b1;
            end else if (s == 2) begin
                expAn = 8'hFB; expSeg = 7'h02; expDp = 1'b0;
            end else begin
                expAn = 8'hFF; expSeg = 7'h7F; expDp = 1'b1;
            end
            total++;
            if (an !== expAn || seg !== expSeg || dp !== expDp) begin
                bad++;
                $display("[TB] FAIL masks slot=%0d an=%h seg=%h dp=%b required an=%h seg=%h dp=%b", s, an, seg, dp, expAn, expSeg, expDp);
            end
        end
    endtask

    task automatic test_readback();
        logic [31:0] rd;
        applyStimulus(4'd1, 32'hFFFFFFFF);
        readReg(4'd1, rd);
        total++;
        if (rd !== 32'h000000FF) begin
            bad++;
            $display("[TB] FAIL rb_digmask got=%h required=000000ff", rd);
        end
        applyStimulus(4'd2, 32'hFFFFFFFF);
        readReg(4'd2, rd);
        total++;
        if (rd !== 32'h000000FF) begin
            bad++;
            $display("[TB] FAIL rb_dpmask got=%h required=000000ff", rd);
        end
        applyStimulus(4'd3, 32'hFFFFFFFF);
        readReg(4'd3, rd);
        total++;
        if (rd !== 32'h00000001) begin
            bad++;
            $display("[TB] FAIL rb_ctrl got=%h required=00000001", rd);
        end
        applyStimulus(4'd9, 32'hDEADBEEF);
        readReg(4'd9, rd);
        total++;
        if (rd !== 32'h0) begin
            bad++;
            $display("[TB] FAIL rb_unused got=%h required=0", rd);
        end
        // Read and write address 0 on the same edge
        @(negedge clk);
        addra = 4'd0;
        dina  = 32'hAABBCCDD;
        wea   = 1'b1;
        @(negedge clk);
        wea   = 1'b0;
        total++;
        if (douta !== 32'h12345678) begin
            bad++;
            $display("[TB] FAIL rb_rbw_old got=%h required=12345678", douta);
        end
        @(negedge clk);
        total++;
        if (douta !== 32'hAABBCCDD) begin
            bad++;
            $display("[TB] FAIL rb_rbw_new got=%h required=aabbccdd", douta);
        end
    endtask

    task automatic test_reset_mid_scan();
        bit found;
        logic [31:0] rd;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(posedge clk);
            #1;
            if (edgeCount % 32 == 22) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("[TB] FAIL mid_scan_align timeout edge=%0d required edge mod 32 = 22", edgeCount);
        end
        total++;
        if (an !== 8'hDF) begin
            bad++;
            $display("[TB] FAIL pre_reset_lit an=%h required=df", an);
        end
        #1;
        rst = 1'b1;
        #1;
        total++;
        if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || douta !== 32'h0) begin
            bad++;
            $display("[TB] FAIL async_reset an=%h seg=%h dp=%b douta=%h required an=ff seg=7f dp=1 douta=0", an, seg, dp, douta);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            total++;
            if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1) begin
                bad++;
                $display("[TB] FAIL blank_after_midreset cyc=%0d an=%h seg=%h dp=%b required an=ff seg=7f dp=1", i, an, seg, dp);
            end
        end
        readReg(4'd0, rd);
        total++;
        if (rd !== 32'h0) begin
            bad++;
            $display("[TB] FAIL value_cleared got=%h required=0", rd);
        end
    endtask

    task automatic test_decode_sweep();
        int s;
        applyStimulus(4'd0, 32'hFEDCBA98);
        applyStimulus(4'd1, 32'h000000FF);
        applyStimulus(4'd2, 32'h000000FF);
        applyStimulus(4'd3, 32'h00000001);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            s = curSlot();
            total++;
            if (an !== anTab[s] || seg !== segTabB[s] || dp !== 1'b0) begin
                bad++;
                $display("[TB] FAIL decode slot=%0d an=%h seg=%h dp=%b required an=%h seg=%h dp=0", s, an, seg, dp, anTab[s], segTabB[s]);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        addra = 4'd0;
        dina  = 32'h0;
        wea   = 1'b0;
        test_reset();
        test_scan_all();
        test_masks();
        test_readback();
        test_reset_mid_scan();
        test_decode_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
